version_store_ctrl: RTL

VERSION_STORE_CTRL -- requirements
Module: version_store_ctrl

---
 rtl/version_store_ctrl_pkg.sv | 25 ++
 rtl/version_store_ctrl_lookup.sv | 45 ++++
 rtl/version_store_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/version_store_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : version_store_ctrl_pkg
// Brief   : Shared constants and state encoding for the versioned slot store.
// Rev     : 1.0 - initial release
// ============================================================================
package version_store_ctrl_pkg;

    localparam int NUM_SLOTS    = 4;
    localparam int SLOT_IDX_W   = 2;
    // Tag value that is never handed out; marks "no version yet".
    localparam int VERSION_NONE = 0;

    // Round-robin pointer values: which side wins the next read/write conflict.
    localparam logic RR_WRITE = 1'b0;
    localparam logic RR_READ  = 1'b1;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_FLUSH     = 2'd1,
        ST_EXHAUSTED = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/version_store_ctrl_lookup.sv
`default_nettype none
// ============================================================================
// Module : version_store_ctrl_lookup
// Brief  : Picks the valid slot whose tag is the largest one strictly below
//          the requested version; reports a miss when none qualifies.
// Rev    : 1.0 - initial release
// ============================================================================
module version_store_ctrl_lookup
    import version_store_ctrl_pkg::*;
#(
    parameter int BLOCK_SIZE = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic [NUM_SLOTS-1:0]  i_valid,
    input  logic [BLOCK_SIZE-1:0] i_tags [NUM_SLOTS],
    input  logic [DATA_WIDTH-1:0] i_data [NUM_SLOTS],
    input  logic [BLOCK_SIZE-1:0] i_rd_version,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_hit
);

    logic [BLOCK_SIZE-1:0] w_best;
    logic                  w_hit;
    logic [DATA_WIDTH-1:0] w_data;

    // Linear max-below search; a miss leaves data at zero.
    always_comb begin
        w_best = BLOCK_SIZE'(VERSION_NONE);
        w_hit  = 1'b0;
        w_data = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (i_valid[i] && (i_tags[i] < i_rd_version) &&
                (!w_hit || (i_tags[i] > w_best))) begin
                w_hit  = 1'b1;
                w_best = i_tags[i];
                w_data = i_data[i];
            end
        end
    end

    assign o_data = w_data;
    assign o_hit  = w_hit;

endmodule
`default_nettype wire

// File: rtl/version_store_ctrl.sv
`default_nettype none
// ============================================================================
// Module : version_store_ctrl
// Brief  : Four-slot versioned store. Writes receive monotonically increasing
//          tags and evict the oldest slot; reads return the newest entry older
//          than the requested version. Single-ported with round-robin arbitration.
// Rev    : 1.0 - initial release
// ============================================================================
module version_store_ctrl
    import version_store_ctrl_pkg::*;
#(
    parameter int BLOCK_SIZE = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  wrReq,
    input  logic [DATA_WIDTH-1:0] wrData,
    output logic                  wrReady,
    output logic [BLOCK_SIZE-1:0] wrVersion,
    input  logic                  rdReq,
    input  logic [BLOCK_SIZE-1:0] rdVersion,
    output logic                  rdReady,
    output logic                  rdValid,
    input  logic                  rdAccept,
    output logic [DATA_WIDTH-1:0] rdData,
    output logic                  rdHit,
    input  logic                  flushReq,
    output logic                  busy
);

    localparam logic [BLOCK_SIZE-1:0] c_ver_max = '1;

    state_e                state_q, state_d;
    logic [SLOT_IDX_W-1:0] flush_idx_q, flush_idx_d;
    logic [BLOCK_SIZE-1:0] cur_ver_q, cur_ver_d;
    logic [BLOCK_SIZE-1:0] wr_version_q, wr_version_d;
    logic                  rr_q, rr_d;
    logic [NUM_SLOTS-1:0]  valid_q, valid_d;
    logic [BLOCK_SIZE-1:0] tag_q [NUM_SLOTS];
    logic [BLOCK_SIZE-1:0] tag_d [NUM_SLOTS];
    logic [DATA_WIDTH-1:0] data_q [NUM_SLOTS];
    logic [DATA_WIDTH-1:0] data_d [NUM_SLOTS];
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_hit_q, rd_hit_d;

    logic                  w_wr_open, w_rd_open, w_conflict;
    logic                  w_wr_ready, w_rd_ready, w_wr_acc, w_rd_acc;
    logic                  w_flush_last;
    logic [SLOT_IDX_W-1:0] w_victim;
    logic                  w_free_found;
    logic [BLOCK_SIZE-1:0] w_oldest;
    logic [DATA_WIDTH-1:0] w_lk_data;
    logic                  w_lk_hit;

    version_store_ctrl_lookup #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lookup (
        .i_valid      (valid_q),
        .i_tags       (tag_q),
        .i_data       (data_q),
        .i_rd_version (rdVersion),
        .o_data       (w_lk_data),
        .o_hit        (w_lk_hit)
    );

    // Handshake gating: a flush request blocks both sides, and when both sides
    // are eligible only the round-robin winner sees ready.
    always_comb begin
        w_wr_open    = (state_q == ST_RUN) && !flushReq;
        w_rd_open    = (state_q != ST_FLUSH) && !flushReq && (!rd_valid_q || rdAccept);
        w_wr_ready   = w_wr_open && !(rdReq && w_rd_open && (rr_q == RR_READ));
        w_rd_ready   = w_rd_open && !(wrReq && w_wr_open && (rr_q == RR_WRITE));
        w_wr_acc     = wrReq && w_wr_ready;
        w_rd_acc     = rdReq && w_rd_ready;
        w_conflict   = wrReq && rdReq && w_wr_open && w_rd_open;
        w_flush_last = (flush_idx_q == SLOT_IDX_W'(NUM_SLOTS - 1));
    end

    // Write victim: lowest-index free slot, otherwise the oldest tag.
    always_comb begin
        w_victim     = '0;
        w_free_found = 1'b0;
        w_oldest     = tag_q[0];
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!valid_q[i] && !w_free_found) begin
                w_victim     = SLOT_IDX_W'(i);
                w_free_found = 1'b1;
            end
        end
        if (!w_free_found) begin
            for (int i = 1; i < NUM_SLOTS; i++) begin
                if (tag_q[i] < w_oldest) begin
                    w_oldest = tag_q[i];
                    w_victim = SLOT_IDX_W'(i);
                end
            end
        end
    end

    // Next-state logic for the run / flush / exhausted controller.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (flushReq)
                    state_d = ST_FLUSH;
                else if (w_wr_acc && (cur_ver_q == c_ver_max))
                    state_d = ST_EXHAUSTED;
            end
            ST_EXHAUSTED: begin
                if (flushReq)
                    state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (w_flush_last)
                    state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Datapath next values: slot updates, version counter, arbitration pointer
    // and the registered read response.
    always_comb begin
        flush_idx_d  = flush_idx_q;
        cur_ver_d    = cur_ver_q;
        wr_version_d = wr_version_q;
        rr_d         = rr_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        data_d       = data_q;
        rd_valid_d   = rd_valid_q;
        rd_data_d    = rd_data_q;
        rd_hit_d     = rd_hit_q;

        if (state_q == ST_FLUSH) begin
            valid_d[flush_idx_q] = 1'b0;
            tag_d[flush_idx_q]   = BLOCK_SIZE'(VERSION_NONE);
            data_d[flush_idx_q]  = '0;
            flush_idx_d          = flush_idx_q + 1'b1;
            if (w_flush_last) begin
                cur_ver_d = BLOCK_SIZE'(1);
                rr_d      = RR_WRITE;
            end
        end else if (flushReq) begin
            flush_idx_d = '0;
        end

        if (w_wr_acc) begin
            valid_d[w_victim] = 1'b1;
            tag_d[w_victim]   = cur_ver_q;
            data_d[w_victim]  = wrData;
            wr_version_d      = cur_ver_q;
            // The last tag is consumed without wrapping; the counter parks there.
            if (cur_ver_q != c_ver_max)
                cur_ver_d = cur_ver_q + 1'b1;
        end

        if (w_conflict)
            rr_d = ~rr_q;

        if (w_rd_acc) begin
            rd_valid_d = 1'b1;
            rd_data_d  = w_lk_data;
            rd_hit_d   = w_lk_hit;
        end else if (rd_valid_q && rdAccept) begin
            rd_valid_d = 1'b0;
            rd_data_d  = '0;
            rd_hit_d   = 1'b0;
        end
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            state_q <= ST_RUN;
        else
            state_q <= state_d;
    end

    // Datapath registers; reset discards slots and any pending response.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            flush_idx_q  <= '0;
            cur_ver_q    <= BLOCK_SIZE'(1);
            wr_version_q <= BLOCK_SIZE'(VERSION_NONE);
            rr_q         <= RR_WRITE;
            valid_q      <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                tag_q[i]  <= BLOCK_SIZE'(VERSION_NONE);
                data_q[i] <= '0;
            end
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_hit_q     <= 1'b0;
        end else begin
            flush_idx_q  <= flush_idx_d;
            cur_ver_q    <= cur_ver_d;
            wr_version_q <= wr_version_d;
            rr_q         <= rr_d;
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            data_q       <= data_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            rd_hit_q     <= rd_hit_d;
        end
    end

    assign wrReady   = w_wr_ready;
    assign rdReady   = w_rd_ready;
    assign wrVersion = wr_version_q;
    assign rdValid   = rd_valid_q;
    assign rdData    = rd_data_q;
    assign rdHit     = rd_hit_q;
    assign busy      = (state_q != ST_RUN);

endmodule
`default_nettype wire
